mano_timing_ctrl: RTL and testbench

// - Timing/decode generator for the Mano basic computer; drives the T[7:0] and D[7:0] buses read by the per-register control decoders (DR, AR, AC, PC).
// - Contains the sequence counter (SC), the one-hot timing decode, and the opcode register latched from IR at T2.
// - Sits between the IR and all register-control logic; the only sequential source of T/D.

---
 rtl/mano_pkg.sv | 29 ++
 rtl/mano_seq_counter.sv | 29 ++
 rtl/mano_timing_ctrl.sv | 87 ++++++++
 tb/tb_mano_timing_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer control path.
// Opcode D-bit positions and IR field locations.
package mano_pkg;

  localparam int OP_AND = 0;
  localparam int OP_ADD = 1;
  localparam int OP_LDA = 2;
  localparam int OP_STA = 3;
  localparam int OP_BUN = 4;
  localparam int OP_BSA = 5;
  localparam int OP_ISZ = 6;
  localparam int OP_IO  = 7;

  localparam int N_OPC = OP_IO + 1;

  localparam int IR_OPC_MSB = 14;
  localparam int IR_OPC_LSB = 12;
  localparam int IR_I_BIT   = 15;

  function automatic logic [N_OPC-1:0] opc_onehot(
    input logic [IR_OPC_MSB-IR_OPC_LSB:0] opc
  );
    logic [N_OPC-1:0] v;
    v = '0;
    v[opc] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter: clear beats hold beats increment.
// Wraps from T_WIDTH-1 back to 0 with no flag.
module mano_seq_counter #(
  parameter int T_WIDTH = 8,
  localparam int SC_W = $clog2(T_WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            hold,
  output logic [SC_W-1:0] sc
);

  // SC register with rst > clr > hold > increment priority
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= '0;
    end else if (clr) begin
      sc <= '0;
    end else if (!hold) begin
      if (sc == SC_W'(T_WIDTH - 1)) begin
        sc <= '0;
      end else begin
        sc <= sc + SC_W'(1);
      end
    end
  end

endmodule

// File: rtl/mano_timing_ctrl.sv
// Timing/decode generator: SC, one-hot T, registered D/I, R flip-flop.
// Optional interrupt cycle enabled by defining MANO_INTR_CYCLE_EN.
module mano_timing_ctrl
  import mano_pkg::*;
#(
  parameter int T_WIDTH = 8,
  localparam int SC_W = $clog2(T_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        ir,
  input  logic               sc_clr,
  input  logic               halt,
  input  logic               ien,
  input  logic               fgi,
  input  logic               fgo,
  output logic [T_WIDTH-1:0] T,
  output logic [N_OPC-1:0]   D,
  output logic               I,
  output logic [SC_W-1:0]    sc,
  output logic               r
);

  logic t2;
  logic load;
  logic cnt_clr;
  logic unused_in;

  assign t2   = T[2];
  assign load = t2 & ~halt & ~r;

`ifdef MANO_INTR_CYCLE_EN
  logic r_q;
  logic r_set;
  logic r_clr;

  assign r_set = (sc >= SC_W'(3)) & ~halt
               & ien & (fgi | fgo);
  assign r_clr = r_q & t2;
  assign cnt_clr = sc_clr | r_clr;
  assign r = r_q;
  assign unused_in = ^ir[IR_OPC_LSB-1:0];

  // R sets late in the cycle on a pending flag, clears at its own T2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (r_clr) begin
      r_q <= 1'b0;
    end else if (r_set) begin
      r_q <= 1'b1;
    end
  end
`else
  assign cnt_clr = sc_clr;
  assign r = 1'b0;
  assign unused_in = ^{ir[IR_OPC_LSB-1:0], ien, fgi, fgo};
`endif

  mano_seq_counter #(
    .T_WIDTH(T_WIDTH)
  ) u_sc (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .hold(halt),
    .sc  (sc)
  );

  // One-hot decode of the registered SC, no added latency
  always_comb begin
    T = '0;
    T[sc] = 1'b1;
  end

  // Opcode/indirect capture at T2 outside of halt and interrupt cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      D <= '0;
      I <= 1'b0;
    end else if (load) begin
      D <= opc_onehot(ir[IR_OPC_MSB:IR_OPC_LSB]);
      I <= ir[IR_I_BIT];
    end
  end

endmodule

// File: tb/tb_mano_timing_ctrl.sv
// Randomized and directed bench for mano_timing_ctrl.
// Expectations come from a cycle-level behavioural model.
module tb_mano_timing_ctrl;

`ifdef MANO_INTR_CYCLE_EN
  localparam bit INTR = 1'b1;
`else
  localparam bit INTR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        sc_clr, halt, ien, fgi, fgo;
  logic [7:0]  t_o, d_o;
  logic        i_o, r_o;
  logic [2:0]  sc_o;

  int checks = 0;
  int errors = 0;

  int         m_sc;
  logic [7:0] m_d;
  logic       m_i, m_r;

  mano_timing_ctrl #(.T_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ir(ir),
    .sc_clr(sc_clr), .halt(halt),
    .ien(ien), .fgi(fgi), .fgo(fgo),
    .T(t_o), .D(d_o), .I(i_o),
    .sc(sc_o), .r(r_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_t();
    return 8'(1 << m_sc);
  endfunction

  // advance one edge; model follows the rules on the pre-edge inputs
  task automatic tick();
    int         n_sc;
    logic [7:0] n_d;
    logic       n_i, n_r;
    bit         rclr, rset;
    n_sc = m_sc; n_d = m_d; n_i = m_i; n_r = m_r;
    if (rst) begin
      n_sc = 0; n_d = 0; n_i = 0; n_r = 0;
    end else begin
      rclr = INTR && m_r && m_sc == 2;
      rset = INTR && m_sc >= 3 && !halt && ien && (fgi || fgo);
      if (m_sc == 2 && !halt && !m_r) begin
        n_d = 8'(1 << ir[14:12]);
        n_i = ir[15];
      end
      if (rclr || sc_clr) n_sc = 0;
      else if (!halt) n_sc = (m_sc + 1) % 8;
      if (rclr) n_r = 0;
      else if (rset) n_r = 1;
    end
    @(posedge clk);
    #1;
    m_sc = n_sc; m_d = n_d; m_i = n_i; m_r = n_r;
  endtask

  task automatic idle_inputs();
    rst = 0; sc_clr = 0; halt = 0;
    ien = 0; fgi = 0; fgo = 0;
  endtask

  task automatic run_to(input int k);
    int n;
    n = 0;
    while (m_sc != k && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (m_sc != k || sc_o !== 3'(k)) begin
      errors++;
      $display("FAIL run_to: sc=%0d required %0d", sc_o, k);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ir = 16'h0;
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++;
    if (t_o !== 8'h01 || sc_o !== 3'd0 || d_o !== 8'h00
        || i_o !== 1'b0 || r_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: T=%h sc=%0d D=%h I=%b r=%b required 01 0 00 0 0",
               t_o, sc_o, d_o, i_o, r_o);
    end
  endtask

  task automatic test_free_run();
    logic [7:0] exp_t;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      exp_t = 8'(1 << (k % 8));
      checks++;
      if (t_o !== exp_t || sc_o !== 3'(k % 8)) begin
        errors++;
        $display("FAIL free_run[%0d]: T=%h sc=%0d required %h %0d",
                 k, t_o, sc_o, exp_t, k % 8);
      end
    end
  endtask

  task automatic test_load_opc();
    ir = 16'h7800;
    run_to(2);
    tick();
    checks++;
    if (d_o !== 8'h80 || i_o !== 1'b0) begin
      errors++;
      $display("FAIL load_opc: D=%h I=%b required 80 0", d_o, i_o);
    end
    run_to(4);
    ir = 16'hB000;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (d_o !== 8'h80 || i_o !== 1'b0) begin
        errors++;
        $display("FAIL load_hold: D=%h I=%b required 80 0", d_o, i_o);
      end
    end
  endtask

  task automatic test_clr_at_t2();
    ir = 16'hA123;
    run_to(2);
    sc_clr = 1;
    tick();
    sc_clr = 0;
    checks++;
    if (t_o !== 8'h01 || d_o !== 8'h04 || i_o !== 1'b1) begin
      errors++;
      $display("FAIL clr_at_t2: T=%h D=%h I=%b required 01 04 1",
               t_o, d_o, i_o);
    end
  endtask

  task automatic test_halt();
    run_to(3);
    halt = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (t_o !== 8'h08) begin
        errors++;
        $display("FAIL halt[%0d]: T=%h required 08", k, t_o);
      end
    end
    sc_clr = 1;
    tick();
    sc_clr = 0;
    halt = 0;
    checks++;
    if (t_o !== 8'h01) begin
      errors++;
      $display("FAIL halt_clr: T=%h required 01", t_o);
    end
  endtask

  task automatic test_reset_mid();
    ir = 16'h4000;
    run_to(2);
    tick();
    run_to(5);
    checks++;
    if (d_o !== 8'h10) begin
      errors++;
      $display("FAIL reset_mid_pre: D=%h required 10", d_o);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (t_o !== 8'h01 || d_o !== 8'h00 || i_o !== 1'b0 || r_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: T=%h D=%h I=%b r=%b required 01 00 0 0",
               t_o, d_o, i_o, r_o);
    end
  endtask

  task automatic test_intr();
    logic [7:0] exp_d;
    ir = 16'h1000;
    run_to(2);
    tick();
    run_to(3);
    ien = 1; fgi = 1;
    tick();
    ien = 0; fgi = 0;
    checks++;
    if (r_o !== INTR) begin
      errors++;
      $display("FAIL intr_set: r=%b required %b", r_o, INTR);
    end
    ir = 16'h6000;
    run_to(2);
    tick();
    exp_d = INTR ? 8'h02 : 8'h40;
    checks++;
    if (r_o !== 1'b0 || d_o !== exp_d || t_o !== m_t()) begin
      errors++;
      $display("FAIL intr_clr: r=%b D=%h T=%h required 0 %h %h",
               r_o, d_o, t_o, exp_d, m_t());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst    = ($urandom_range(0, 39) == 0);
      sc_clr = ($urandom_range(0, 9) == 0);
      halt   = ($urandom_range(0, 5) == 0);
      ien    = $urandom_range(0, 1) == 1;
      fgi    = ($urandom_range(0, 3) == 0);
      fgo    = ($urandom_range(0, 3) == 0);
      ir     = 16'($urandom);
      tick();
      checks++;
      if (t_o !== m_t() || sc_o !== 3'(m_sc) || d_o !== m_d
          || i_o !== m_i || r_o !== m_r) begin
        errors++;
        $display("FAIL random[%0d]: T=%h sc=%0d D=%h I=%b r=%b required %h %0d %h %b %b",
                 k, t_o, sc_o, d_o, i_o, r_o,
                 m_t(), m_sc, m_d, m_i, m_r);
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_sc = 0; m_d = 0; m_i = 0; m_r = 0;
    test_reset();
    test_free_run();
    test_load_opc();
    test_clr_at_t2();
    test_halt();
    test_reset_mid();
    test_intr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
